pipe_hazard_ctrl: RTL and testbench

//  Parametrised hazard, stall and forwarding controller for the in-order pipeline. Replaces the fixed control block.

---
 rtl/pipe_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and forwarding control for the in-order pipeline.
// Scoreboard of in-flight results after ID; youngest ready source wins.
module pipe_hazard_ctrl #(
    parameter int DW        = 32,
    parameter int RAW       = 5,
    parameter int DEPTH     = 3,
    parameter int LOAD_STG  = 1,
    parameter int MC_LAT    = 4,
    localparam int SELW     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  id_valid,
    input  logic [RAW-1:0]        id_rs_addr,
    input  logic [RAW-1:0]        id_rt_addr,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [RAW-1:0]        id_dst_addr,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_multi,
    input  logic                  redirect,
    input  logic [DEPTH*DW-1:0]   fwd_data,
    input  logic [DW-1:0]         rf_rs_data,
    input  logic [DW-1:0]         rf_rt_data,
    output logic                  stall_if,
    output logic                  bubble_ex,
    output logic                  flush_if,
    output logic [SELW-1:0]       fwd_sel_rs,
    output logic [SELW-1:0]       fwd_sel_rt,
    output logic [DW-1:0]         rs_fwd,
    output logic [DW-1:0]         rt_fwd,
    output logic                  mc_busy
);

    localparam int CW = $clog2(MC_LAT + 1);

    logic [DEPTH-1:0] sb_valid;
    logic [DEPTH-1:0] sb_wr;
    logic [DEPTH-1:0] sb_load;
    logic [RAW-1:0]   sb_dst [DEPTH];
    logic [CW-1:0]    mc_cnt;

    logic            rs_chk, rt_chk;
    logic            rs_hit, rt_hit;
    logic            rs_rdy, rt_rdy;
    logic [SELW-1:0] rs_idx, rt_idx;
    logic [DW-1:0]   rs_data, rt_data;
    logic            rs_ok, rt_ok;
    logic            load_use;
    logic            stall;
    logic            issue;

    assign rs_chk = id_rs_used && (id_rs_addr != '0);
    assign rt_chk = id_rt_used && (id_rt_addr != '0);

    // Scan oldest to youngest so the youngest match overwrites the result.
    always_comb begin
        rs_hit  = 1'b0;
        rs_rdy  = 1'b0;
        rs_idx  = '0;
        rs_data = '0;
        rt_hit  = 1'b0;
        rt_rdy  = 1'b0;
        rt_idx  = '0;
        rt_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (sb_valid[k] && sb_wr[k] && rs_chk &&
                sb_dst[k] == id_rs_addr) begin
                rs_hit  = 1'b1;
                rs_idx  = SELW'(k);
                rs_rdy  = !sb_load[k] || (k >= LOAD_STG);
                rs_data = fwd_data[k*DW +: DW];
            end
            if (sb_valid[k] && sb_wr[k] && rt_chk &&
                sb_dst[k] == id_rt_addr) begin
                rt_hit  = 1'b1;
                rt_idx  = SELW'(k);
                rt_rdy  = !sb_load[k] || (k >= LOAD_STG);
                rt_data = fwd_data[k*DW +: DW];
            end
        end
    end

    assign rs_ok    = rs_hit && rs_rdy;
    assign rt_ok    = rt_hit && rt_rdy;
    assign load_use = (rs_hit && !rs_rdy) || (rt_hit && !rt_rdy);

    assign mc_busy  = (mc_cnt != '0);
    assign stall    = load_use || mc_busy;
    assign issue    = id_valid && !stall;

    assign stall_if   = stall;
    assign bubble_ex  = stall;
    assign flush_if   = redirect && !stall;

    assign fwd_sel_rs = rs_ok ? rs_idx + 1'b1 : '0;
    assign fwd_sel_rt = rt_ok ? rt_idx + 1'b1 : '0;
    assign rs_fwd     = rs_ok ? rs_data : rf_rs_data;
    assign rt_fwd     = rt_ok ? rt_data : rf_rt_data;

    always_ff @(posedge clk) begin
        if (reset_) begin
            sb_valid <= '0;
            sb_wr    <= '0;
            sb_load  <= '0;
            mc_cnt   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                sb_dst[k] <= '0;
            end
        end else begin
            sb_valid[0] <= issue;
            sb_wr[0]    <= id_reg_write;
            sb_load[0]  <= id_mem_read;
            sb_dst[0]   <= id_dst_addr;
            for (int k = 1; k < DEPTH; k++) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_wr[k]    <= sb_wr[k-1];
                sb_load[k]  <= sb_load[k-1];
                sb_dst[k]   <= sb_dst[k-1];
            end
            if (issue && id_multi) begin
                mc_cnt <= CW'(MC_LAT);
            end else if (mc_busy) begin
                mc_cnt <= mc_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus checked against an in-flight instruction queue model.
module tb_pipe_hazard_ctrl;

    localparam int DW       = 32;
    localparam int RAW      = 5;
    localparam int DEPTH    = 3;
    localparam int LOAD_STG = 1;
    localparam int MC_LAT   = 4;
    localparam int SELW     = $clog2(DEPTH + 1);

    logic                clk;
    logic                reset_;
    logic                id_valid;
    logic [RAW-1:0]      id_rs_addr, id_rt_addr, id_dst_addr;
    logic                id_rs_used, id_rt_used;
    logic                id_reg_write, id_mem_read, id_multi;
    logic                redirect;
    logic [DEPTH*DW-1:0] fwd_data;
    logic [DW-1:0]       rf_rs_data, rf_rt_data;
    logic                stall_if, bubble_ex, flush_if, mc_busy;
    logic [SELW-1:0]     fwd_sel_rs, fwd_sel_rt;
    logic [DW-1:0]       rs_fwd, rt_fwd;

    pipe_hazard_ctrl #(
        .DW(DW), .RAW(RAW), .DEPTH(DEPTH),
        .LOAD_STG(LOAD_STG), .MC_LAT(MC_LAT)
    ) dut (
        .clk(clk), .reset_(reset_),
        .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_dst_addr(id_dst_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_multi(id_multi),
        .redirect(redirect), .fwd_data(fwd_data),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
        .stall_if(stall_if), .bubble_ex(bubble_ex),
        .flush_if(flush_if),
        .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt),
        .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .mc_busy(mc_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit       v;
        bit [4:0] dst;
        bit       wr;
        bit       ld;
    } ent_t;

    // pipe[0] is the instruction one stage past ID (EX)
    ent_t pipe[$];
    int   mc_left;

    bit          exp_stall, exp_flush, exp_busy;
    int          exp_sel_rs, exp_sel_rt;
    bit [DW-1:0] exp_rs, exp_rt;

    function automatic void model_eval();
        int  ks, kt;
        bit  rs_ready, rt_ready;
        ks = -1;
        kt = -1;
        for (int k = 0; k < DEPTH; k++) begin
            if (ks < 0 && pipe[k].v && pipe[k].wr && id_rs_used &&
                id_rs_addr != 0 && pipe[k].dst == id_rs_addr)
                ks = k;
            if (kt < 0 && pipe[k].v && pipe[k].wr && id_rt_used &&
                id_rt_addr != 0 && pipe[k].dst == id_rt_addr)
                kt = k;
        end
        rs_ready = (ks >= 0) && (!pipe[ks].ld || ks >= LOAD_STG);
        rt_ready = (kt >= 0) && (!pipe[kt].ld || kt >= LOAD_STG);
        exp_busy   = (mc_left > 0);
        exp_stall  = exp_busy || (ks >= 0 && !rs_ready) ||
                     (kt >= 0 && !rt_ready);
        exp_flush  = redirect && !exp_stall;
        exp_sel_rs = rs_ready ? ks + 1 : 0;
        exp_sel_rt = rt_ready ? kt + 1 : 0;
        exp_rs     = rs_ready ? fwd_data[ks*DW +: DW] : rf_rs_data;
        exp_rt     = rt_ready ? fwd_data[kt*DW +: DW] : rf_rt_data;
    endfunction

    task automatic model_clock();
        ent_t e;
        if (reset_) begin
            for (int k = 0; k < DEPTH; k++) pipe[k] = '{default: 0};
            mc_left = 0;
        end else begin
            e.v   = id_valid && !exp_stall;
            e.dst = id_dst_addr;
            e.wr  = id_reg_write;
            e.ld  = id_mem_read;
            pipe.push_front(e);
            void'(pipe.pop_back());
            if (mc_left > 0) mc_left--;
            else if (e.v && id_multi) mc_left = MC_LAT;
        end
    endtask

    task automatic cycle();
        model_eval();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic drive_id(input bit v, input int rs, input bit rsu,
                            input int rt, input bit rtu, input int dst,
                            input bit wr, input bit ld, input bit mul);
        id_valid     = v;
        id_rs_addr   = RAW'(rs);
        id_rs_used   = rsu;
        id_rt_addr   = RAW'(rt);
        id_rt_used   = rtu;
        id_dst_addr  = RAW'(dst);
        id_reg_write = wr;
        id_mem_read  = ld;
        id_multi     = mul;
    endtask

    task automatic drain();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        redirect = 1'b0;
        repeat (DEPTH + MC_LAT + 1) cycle();
    endtask

    task automatic test_reset();
        reset_ = 1'b1;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        reset_ = 1'b0;
        drive_id(1, 3, 1, 4, 1, 0, 0, 0, 0);
        rf_rs_data = 32'h1111_2222;
        rf_rt_data = 32'h3333_4444;
        #1;
        checks++;
        if (stall_if !== 1'b0 || mc_busy !== 1'b0 || bubble_ex !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got stall=%b busy=%b bub=%b want 0",
                     stall_if, mc_busy, bubble_ex);
        end
        checks++;
        if (fwd_sel_rs !== 0 || fwd_sel_rt !== 0 ||
            rs_fwd !== 32'h1111_2222 || rt_fwd !== 32'h3333_4444) begin
            errors++;
            $display("FAIL reset_fwd: sel=%0d/%0d data=%h/%h want 0/0 11112222/33334444",
                     fwd_sel_rs, fwd_sel_rt, rs_fwd, rt_fwd);
        end
        cycle();
    endtask

    task automatic test_fwd_basic();
        drain();
        fwd_data = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        drive_id(1, 0, 0, 0, 0, 3, 1, 0, 0);
        cycle();
        drive_id(1, 3, 1, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (fwd_sel_rs !== 2'd1 || rs_fwd !== 32'hAAAA_0001 || stall_if !== 1'b0) begin
            errors++;
            $display("FAIL fwd_ex: sel=%0d data=%h stall=%b want 1 aaaa0001 0",
                     fwd_sel_rs, rs_fwd, stall_if);
        end
        drain();
        drive_id(1, 0, 0, 0, 0, 3, 1, 0, 0);
        cycle();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        drive_id(1, 3, 1, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (fwd_sel_rs !== 2'd3 || rs_fwd !== 32'hCCCC_0003) begin
            errors++;
            $display("FAIL fwd_wb: sel=%0d data=%h want 3 cccc0003",
                     fwd_sel_rs, rs_fwd);
        end
        cycle();
    endtask

    task automatic test_load_use();
        drain();
        fwd_data = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
        rf_rt_data = 32'h0000_0055;
        drive_id(1, 0, 0, 0, 0, 5, 1, 1, 0);
        cycle();
        drive_id(1, 0, 0, 5, 1, 0, 0, 0, 0);
        redirect = 1'b1;
        #1;
        checks++;
        if (stall_if !== 1'b1 || bubble_ex !== 1'b1 || flush_if !== 1'b0 ||
            fwd_sel_rt !== 0 || rt_fwd !== 32'h0000_0055) begin
            errors++;
            $display("FAIL load_use_stall: stall=%b bub=%b flush=%b sel=%0d d=%h want 1 1 0 0 00000055",
                     stall_if, bubble_ex, flush_if, fwd_sel_rt, rt_fwd);
        end
        cycle();
        #1;
        checks++;
        if (stall_if !== 1'b0 || flush_if !== 1'b1 ||
            fwd_sel_rt !== 2'd2 || rt_fwd !== 32'h2000_0000) begin
            errors++;
            $display("FAIL load_use_release: stall=%b flush=%b sel=%0d d=%h want 0 1 2 20000000",
                     stall_if, flush_if, fwd_sel_rt, rt_fwd);
        end
        redirect = 1'b0;
        cycle();
    endtask

    task automatic test_r0();
        drain();
        fwd_data = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001};
        rf_rs_data = 32'h0;
        drive_id(1, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle();
        drive_id(1, 0, 1, 0, 1, 0, 0, 0, 0);
        #1;
        checks++;
        if (fwd_sel_rs !== 0 || rs_fwd !== 32'h0 || stall_if !== 1'b0) begin
            errors++;
            $display("FAIL r0: sel=%0d d=%h stall=%b want 0 0 0",
                     fwd_sel_rs, rs_fwd, stall_if);
        end
        cycle();
    endtask

    task automatic test_youngest();
        drain();
        fwd_data = {32'h0000_00CC, 32'h0000_00BB, 32'h0000_00AA};
        drive_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
        cycle();
        cycle();
        drive_id(1, 7, 1, 7, 1, 0, 0, 0, 0);
        #1;
        checks++;
        if (fwd_sel_rs !== 2'd1 || rs_fwd !== 32'hAA ||
            fwd_sel_rt !== 2'd1 || rt_fwd !== 32'hAA) begin
            errors++;
            $display("FAIL youngest: sel=%0d/%0d d=%h/%h want 1/1 aa/aa",
                     fwd_sel_rs, fwd_sel_rt, rs_fwd, rt_fwd);
        end
        cycle();
    endtask

    task automatic test_dual_hazard();
        drain();
        fwd_data = {32'h0000_0333, 32'h0000_0222, 32'h0000_0111};
        drive_id(1, 0, 0, 0, 0, 6, 1, 1, 0);
        cycle();
        drive_id(1, 0, 0, 0, 0, 5, 1, 1, 0);
        cycle();
        drive_id(1, 5, 1, 6, 1, 0, 0, 0, 0);
        #1;
        checks++;
        if (stall_if !== 1'b1 || fwd_sel_rs !== 0 || fwd_sel_rt !== 2'd2) begin
            errors++;
            $display("FAIL dual_stall: stall=%b sel=%0d/%0d want 1 0/2",
                     stall_if, fwd_sel_rs, fwd_sel_rt);
        end
        cycle();
        #1;
        checks++;
        if (stall_if !== 1'b0 || fwd_sel_rs !== 2'd2 || rs_fwd !== 32'h222 ||
            fwd_sel_rt !== 2'd3 || rt_fwd !== 32'h333) begin
            errors++;
            $display("FAIL dual_release: stall=%b sel=%0d/%0d d=%h/%h want 0 2/3 222/333",
                     stall_if, fwd_sel_rs, fwd_sel_rt, rs_fwd, rt_fwd);
        end
        cycle();
    endtask

    task automatic test_multi();
        drain();
        drive_id(1, 0, 0, 0, 0, 9, 1, 0, 1);
        #1;
        checks++;
        if (mc_busy !== 1'b0 || stall_if !== 1'b0) begin
            errors++;
            $display("FAIL mc_issue: busy=%b stall=%b want 0 0", mc_busy, stall_if);
        end
        cycle();
        drive_id(1, 1, 1, 2, 1, 4, 1, 0, 0);
        redirect = 1'b1;
        for (int i = 0; i < MC_LAT; i++) begin
            #1;
            checks++;
            if (mc_busy !== 1'b1 || stall_if !== 1'b1 ||
                bubble_ex !== 1'b1 || flush_if !== 1'b0) begin
                errors++;
                $display("FAIL mc_busy_%0d: busy=%b stall=%b bub=%b flush=%b want 1 1 1 0",
                         i, mc_busy, stall_if, bubble_ex, flush_if);
            end
            cycle();
        end
        #1;
        checks++;
        if (mc_busy !== 1'b0 || stall_if !== 1'b0 || flush_if !== 1'b1) begin
            errors++;
            $display("FAIL mc_release: busy=%b stall=%b flush=%b want 0 0 1",
                     mc_busy, stall_if, flush_if);
        end
        redirect = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid_stall();
        drain();
        drive_id(1, 0, 0, 0, 0, 5, 1, 1, 0);
        cycle();
        drive_id(1, 5, 1, 5, 1, 0, 0, 0, 0);
        #1;
        checks++;
        if (stall_if !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: stall=%b want 1", stall_if);
        end
        reset_ = 1'b1;
        cycle();
        reset_ = 1'b0;
        #1;
        checks++;
        if (stall_if !== 1'b0 || mc_busy !== 1'b0 ||
            fwd_sel_rs !== 0 || fwd_sel_rt !== 0) begin
            errors++;
            $display("FAIL rst_mid_load: stall=%b busy=%b sel=%0d/%0d want 0 0 0/0",
                     stall_if, mc_busy, fwd_sel_rs, fwd_sel_rt);
        end
        drive_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        drive_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        reset_ = 1'b1;
        cycle();
        reset_ = 1'b0;
        #1;
        checks++;
        if (mc_busy !== 1'b0 || stall_if !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_mc: busy=%b stall=%b want 0 0", mc_busy, stall_if);
        end
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            reset_       = ($urandom_range(0, 199) == 0);
            id_valid     = ($urandom_range(0, 3) != 0);
            id_rs_addr   = RAW'($urandom_range(0, 7));
            id_rt_addr   = RAW'($urandom_range(0, 7));
            id_rs_used   = $urandom_range(0, 1);
            id_rt_used   = $urandom_range(0, 1);
            id_dst_addr  = RAW'($urandom_range(0, 7));
            id_reg_write = ($urandom_range(0, 3) != 0);
            id_mem_read  = ($urandom_range(0, 2) == 0);
            id_multi     = ($urandom_range(0, 15) == 0);
            redirect     = ($urandom_range(0, 3) == 0);
            fwd_data     = {$urandom, $urandom, $urandom};
            rf_rs_data   = $urandom;
            rf_rt_data   = $urandom;
            #1;
            model_eval();
            checks++;
            if (stall_if !== exp_stall || bubble_ex !== exp_stall ||
                flush_if !== exp_flush || mc_busy !== exp_busy) begin
                errors++;
                $display("FAIL rand_ctrl n=%0d: stall=%b bub=%b flush=%b busy=%b want %b %b %b %b",
                         n, stall_if, bubble_ex, flush_if, mc_busy,
                         exp_stall, exp_stall, exp_flush, exp_busy);
            end
            checks++;
            if (int'(fwd_sel_rs) != exp_sel_rs || rs_fwd !== exp_rs) begin
                errors++;
                $display("FAIL rand_rs n=%0d: sel=%0d d=%h want %0d %h",
                         n, fwd_sel_rs, rs_fwd, exp_sel_rs, exp_rs);
            end
            checks++;
            if (int'(fwd_sel_rt) != exp_sel_rt || rt_fwd !== exp_rt) begin
                errors++;
                $display("FAIL rand_rt n=%0d: sel=%0d d=%h want %0d %h",
                         n, fwd_sel_rt, rt_fwd, exp_sel_rt, exp_rt);
            end
            cycle();
        end
        reset_ = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (DEPTH) pipe.push_back('{default: 0});
        mc_left    = 0;
        reset_     = 1'b1;
        redirect   = 1'b0;
        fwd_data   = '0;
        rf_rs_data = '0;
        rf_rt_data = '0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_fwd_basic();
        test_load_use();
        test_r0();
        test_youngest();
        test_dual_hazard();
        test_multi();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
